// File: rtl/fabric_data_memslave.sv
// Memory-side responder on the four-lane fabric data bus: decodes its bank in the address
// phase, then serves one 4-word block write or read and acks each phase on BUSY_line_SLAVE.
module fabric_data_memslave #(
  parameter int SEG_W     = 8,
  parameter int ADDR_W    = 10,
  parameter int BANK      = 0,
  parameter int TIMEOUT   = 255,
  parameter int DRIVE_CYC = 2
) (
  input  logic             CLK_B,
  input  logic             RESET,
  inout  wire  [SEG_W-1:0] SA_D3,
  inout  wire  [SEG_W-1:0] SB_D2,
  inout  wire  [SEG_W-1:0] SC_D1,
  inout  wire  [SEG_W-1:0] IP_D0,
  input  logic             ADDRFD,
  input  logic             WRITEFD,
  input  logic             READFD,
  input  logic             BUSY_line_MASTER,
  output logic             BUSY_line_SLAVE,
  output logic             ACTIVE,
  output logic             ERR_TIMEOUT
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam int DC_W  = $clog2(DRIVE_CYC + 1);
  localparam logic [SEG_W-1:0] BANK_V = SEG_W'(BANK);

  typedef enum logic [2:0] {
    S_IDLE, S_AACK, S_WAIT, S_WRITE, S_WACK, S_READ, S_DRIVE
  } state_e;

  state_e                  state_q;
  logic                    busy_q, err_q, drv_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [DC_W-1:0]         dcnt_q;
  logic [1:0]              k_q;
  logic [ADDR_W-1:0]       base_q;
  logic [3:0][SEG_W-1:0]   wbuf_q, rbuf_q;
  logic [SEG_W-1:0]        mem [2**ADDR_W];

  // Word k lives on lane k, with word 0 on SA_D3.
  logic [3:0][SEG_W-1:0]   lane_in;
  logic [2*SEG_W-1:0]      addr_raw;
  logic [ADDR_W-1:0]       base_d, maddr;
  logic                    bank_hit;

  assign lane_in  = {IP_D0, SC_D1, SB_D2, SA_D3};
  assign addr_raw = {SC_D1, IP_D0};
  assign base_d   = {addr_raw[ADDR_W-1:2], 2'b00};
  assign bank_hit = ADDRFD && !BUSY_line_MASTER && (SA_D3 == BANK_V);
  assign maddr    = {base_q[ADDR_W-1:2], k_q};

  always_ff @(posedge CLK_B or negedge RESET) begin
    if (!RESET) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      drv_q   <= 1'b0;
      cnt_q   <= '0;
      dcnt_q  <= '0;
      k_q     <= '0;
      base_q  <= '0;
      wbuf_q  <= '0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        S_IDLE: if (bank_hit) begin
          base_q  <= base_d;
          busy_q  <= 1'b1;
          state_q <= S_AACK;
        end
        S_AACK: begin
          busy_q  <= 1'b0;
          cnt_q   <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (bank_hit) begin
            base_q  <= base_d;
            busy_q  <= 1'b1;
            state_q <= S_AACK;
          end else if (WRITEFD) begin
            wbuf_q  <= lane_in;
            k_q     <= '0;
            state_q <= S_WRITE;
          end else if (READFD) begin
            k_q     <= '0;
            state_q <= S_READ;
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            err_q   <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_WRITE: begin
          k_q <= k_q + 1'b1;
          if (k_q == 2'd3) begin
            busy_q  <= 1'b1;
            state_q <= S_WACK;
          end
        end
        S_WACK: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        S_READ: begin
          k_q <= k_q + 1'b1;
          if (k_q == 2'd3) begin
            busy_q  <= 1'b1;
            drv_q   <= 1'b1;
            dcnt_q  <= '0;
            state_q <= S_DRIVE;
          end
        end
        S_DRIVE: begin
          if (dcnt_q == DC_W'(DRIVE_CYC - 1)) begin
            busy_q  <= 1'b0;
            drv_q   <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            dcnt_q <= dcnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Array and read buffer are not reset; the state gating stops any access once reset hits.
  always_ff @(posedge CLK_B) begin
    if (state_q == S_WRITE) mem[maddr] <= wbuf_q[k_q];
    if (state_q == S_READ)  rbuf_q[k_q] <= mem[maddr];
  end

  assign SA_D3 = drv_q ? rbuf_q[0] : 'z;
  assign SB_D2 = drv_q ? rbuf_q[1] : 'z;
  assign SC_D1 = drv_q ? rbuf_q[2] : 'z;
  assign IP_D0 = drv_q ? rbuf_q[3] : 'z;

  assign BUSY_line_SLAVE = busy_q;
  assign ERR_TIMEOUT     = err_q;
  assign ACTIVE          = (state_q != S_IDLE);

endmodule
